// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W=4*NIBBLES adder built from one 4-bit RCA, one nibble per clock.
// Define NSA_SUB_EN to add the `sub` input (a - b via ~b and carry-in 1).

module RCA (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[4];
   end
endmodule

module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
`ifdef NSA_SUB_EN
   input  logic                 sub,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t state;
   state_t state_nx;

   logic [W-1:0]  wa;
   logic [W-1:0]  wb;
   logic          carry;
   logic [IW-1:0] idx;
   logic [3:0]    rca_sum;
   logic          rca_cout;
   logic [W-1:0]  res;
   logic [W-1:0]  b_in;
   logic          c_in;
   logic          accept;
   logic          last;

`ifdef NSA_SUB_EN
   assign b_in = sub ? ~b : b;
   assign c_in = sub | cin;
`else
   assign b_in = b;
   assign c_in = cin;
`endif

   assign accept = start && (state != RUN);
   assign last   = (state == RUN) && (idx == IW'(NIBBLES - 1));

   RCA u_rca (
      .a    (wa[3:0]),
      .b    (wb[3:0]),
      .cin  (carry),
      .sum  (rca_sum),
      .cout (rca_cout)
   );

   // Result nibbles enter at the top; after NIBBLES shifts slice 0 sits at bit 0.
   generate
      if (NIBBLES > 1) begin : g_acc
         logic [W-5:0] acc;

         always_ff @(posedge clk) begin
            if (rst) begin
               acc <= '0;
            end else if (state == RUN) begin
               acc <= res[W-1:4];
            end
         end

         assign res = {rca_sum, acc};
      end else begin : g_one
         assign res = rca_sum;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wa    <= '0;
         wb    <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         wa    <= a;
         wb    <= b_in;
         carry <= c_in;
         idx   <= '0;
      end else if (state == RUN) begin
         wa    <= wa >> 4;
         wb    <= wb >> 4;
         carry <= rca_cout;
         idx   <= idx + IW'(1);
         if (last) begin
            sum  <= res;
            cout <= rca_cout;
         end
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: reference model pushes a+b+cin
// results on accepted starts; a monitor pops them on every done pulse.

module tb_nibble_serial_adder;
   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic         cin   = 1'b0;
   logic         sub   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic         cout;
   logic [W-1:0] sum;

   int checks = 0;
   int errors = 0;
   int done_count = 0;

   logic [W:0] q[$];
   logic [W:0] last_res = '0;
   int         cnt = 0;
   logic       exp_done = 1'b0;
   logic       exp_busy = 1'b0;
   logic       seen_rst = 1'b0;

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef NSA_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   function automatic logic [W:0] ref_result(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic c,
                                             input logic s);
      logic [W:0] r;
      if (s) r = {1'b0, x} + ((W+1)'(1) << W) - {1'b0, y};
      else   r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      return r;
   endfunction

   task automatic chk(input string name, input logic [W:0] act,
                      input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted op occupies N busy cycles, then one done cycle.
   always @(posedge clk) begin
      exp_done = 1'b0;
      if (rst) begin
         cnt = 0;
         q.delete();
         last_res = '0;
         seen_rst = 1'b1;
      end else if (cnt == 0 && start) begin
         cnt = N;
         q.push_back(ref_result(a, b, cin, sub));
      end else if (cnt > 0) begin
         cnt--;
         exp_done = (cnt == 0);
      end
      exp_busy = (cnt > 0);
   end

   always @(posedge clk) begin
      #1;
      if (seen_rst) begin
         chk("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, exp_busy});
         chk("done", {{W{1'b0}}, done}, {{W{1'b0}}, exp_done});
         if (done === 1'b1) begin
            done_count++;
            if (q.size() == 0) begin
               chk("unexpected_done", {{W{1'b0}}, done}, '0);
            end else begin
               last_res = q.pop_front();
            end
         end
         chk("result", {cout, sum}, last_res);
      end
   end

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s);
      start = 1'b1;
      a = x;
      b = y;
      cin = c;
      sub = s;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      sub = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic c,
                         input logic s, input logic [W:0] exp);
      issue(x, y, c, s);
      repeat (N) @(negedge clk);
      chk({name, "_done"}, {{W{1'b0}}, done}, (W+1)'(1));
      chk(name, {cout, sum}, exp);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int dc0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_out", {busy, done, cout, sum}, '0);
      rst = 1'b0;
      @(negedge clk);

      run_op("add_1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555);
      run_op("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
      run_op("ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000);

      dc0 = done_count;
      issue(16'h0010, 16'h0020, 1'b0, 1'b0);
      @(negedge clk);
      issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("ignored_start", {cout, sum}, 17'h00030);
      repeat (3) @(negedge clk);
      chk("one_done", (W+1)'(done_count), (W+1)'(dc0 + 1));

      issue(16'h0001, 16'h0002, 1'b0, 1'b0);
      repeat (N) @(negedge clk);
      chk("b2b_first", {cout, sum}, 17'h00003);
      issue(16'h8000, 16'h8000, 1'b0, 1'b0);
      chk("b2b_hold0", {cout, sum}, 17'h00003);
      repeat (N - 1) @(negedge clk);
      chk("b2b_hold3", {cout, sum}, 17'h00003);
      @(negedge clk);
      chk("b2b_second", {cout, sum}, 17'h10000);
      chk("b2b_done", {{W{1'b0}}, done}, (W+1)'(1));
      @(negedge clk);

      issue(16'h0123, 16'h0456, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_reset", {busy, done, cout, sum}, '0);
      dc0 = done_count;
      repeat (N + 2) @(negedge clk);
      chk("no_done_after_rst", (W+1)'(done_count), (W+1)'(dc0));
      run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 17'h00002);

`ifdef NSA_SUB_EN
      run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE);
      run_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002);
`endif

      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         start = ($urandom_range(0, 2) != 0);
         a = W'($urandom);
         b = W'($urandom);
         cin = 1'($urandom);
`ifdef NSA_SUB_EN
         sub = 1'($urandom);
`endif
         @(negedge clk);
      end
      rst = 1'b0;
      start = 1'b0;
      repeat (N + 3) @(negedge clk);
      chk("queue_drained", (W+1)'(q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
